// File: rtl/hdmi_pkg.sv
// Shared types for the HDMI video path: pixel word, raster defaults, feeder FSM states.
package hdmi_pkg;

    typedef struct packed {
        bit       sof;
        bit [7:0] r;
        bit [7:0] g;
        bit [7:0] b;
    } pixel_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic {
        SYNC   = 1'b0,
        STREAM = 1'b1
    } feeder_state_t;

    function automatic pixel_t make_pixel(input logic sof, input logic [23:0] rgb);
        pixel_t p;
        p.sof = sof;
        p.r   = rgb[23:16];
        p.g   = rgb[15:8];
        p.b   = rgb[7:0];
        return p;
    endfunction

endpackage

// File: rtl/hdmi_pixel_feeder_if.sv
// Pixel stream in from scan-out and pixel stream out to the HDMI top level.
interface hdmi_pixel_feeder_if;

    logic [23:0] in_data;
    logic        in_sof;
    logic        in_valid;
    logic        in_rdy;

    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        video_valid;
    logic        video_rdy;

    // slave: the feeder itself; master: the surrounding environment
    modport slave (
        input  in_data, in_sof, in_valid, video_rdy,
        output in_rdy, r, g, b, video_valid
    );

    modport master (
        output in_data, in_sof, in_valid, video_rdy,
        input  in_rdy, r, g, b, video_valid
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout always shows the head entry.
module sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hdmi_pixel_feeder.sv
// Buffers scan-out pixels, aligns them to the raster and feeds the HDMI pixel port.
//
// state  | meaning
// SYNC   | hunting for a start-of-frame pixel; non-sof head entries are dropped
// STREAM | forwarding pixels, checking sof against the expected raster position
module hdmi_pixel_feeder
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int DEPTH    = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    hdmi_pixel_feeder_if.slave      vid,
    output logic                    frame_start,
    output logic [$clog2(DEPTH):0]  fill,
    output logic [15:0]             underflow_cnt,
    output logic [7:0]              resync_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    feeder_state_t state_q, state_d;
    pixel_t        out_pix_q, out_pix_d;
    logic          out_valid_q, out_valid_d;
    logic          out_first_q, out_first_d;
    logic [XW-1:0] x_q, x_d, base_x;
    logic [YW-1:0] y_q, y_d, base_y;

    pixel_t        head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          wr_en;
    logic          pop;
    logic          load;
    logic          restart;
    logic          resync_evt;
    logic          underflow_evt;
    logic          consume;
    logic          slot_free;
    logic          at_origin;
    logic          in_rdy_q;
    logic          in_rdy_d;

    assign vid.in_rdy = in_rdy_q && !rst;
    assign wr_en      = vid.in_valid && vid.in_rdy;

    sync_fifo #(
        .WIDTH ($bits(pixel_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (make_pixel(vid.in_sof, vid.in_data)),
        .rd_en (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill)
    );

    assign vid.r           = out_pix_q.r;
    assign vid.g           = out_pix_q.g;
    assign vid.b           = out_pix_q.b;
    assign vid.video_valid = out_valid_q;

    assign consume       = out_valid_q && vid.video_rdy;
    assign slot_free     = !out_valid_q || vid.video_rdy;
    assign at_origin     = (x_q == '0) && (y_q == '0);
    assign underflow_evt = (state_q == STREAM) && vid.video_rdy && !out_valid_q && fifo_empty;

    // in_rdy tracks next-cycle occupancy so it is never high while the FIFO is full
    assign in_rdy_d = !((fifo_full && !pop) ||
                        ((fill == CW'(DEPTH - 1)) && wr_en && !pop));

    always_comb begin
        state_d     = state_q;
        out_pix_d   = out_pix_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        x_d         = x_q;
        y_d         = y_q;
        pop         = 1'b0;
        load        = 1'b0;
        restart     = 1'b0;
        resync_evt  = 1'b0;

        if (slot_free) begin
            out_valid_d = 1'b0;
            if (!fifo_empty) begin
                pop = 1'b1;
                case (state_q)
                    SYNC: begin
                        if (head.sof) begin
                            load    = 1'b1;
                            restart = 1'b1;
                            state_d = STREAM;
                        end
                    end
                    STREAM: begin
                        if (head.sof && !at_origin) begin
                            load       = 1'b1;
                            restart    = 1'b1;
                            resync_evt = 1'b1;
                        end else if (!head.sof && at_origin) begin
                            resync_evt = 1'b1;
                            state_d    = SYNC;
                        end else begin
                            load = 1'b1;
                        end
                    end
                    default: state_d = SYNC;
                endcase
            end
        end

        // x/y hold the raster position the next loaded pixel will take
        base_x = restart ? '0 : x_q;
        base_y = restart ? '0 : y_q;

        if (load) begin
            out_pix_d   = head;
            out_valid_d = 1'b1;
            out_first_d = (base_x == '0) && (base_y == '0);
            if (base_x == XW'(H_ACTIVE - 1)) begin
                x_d = '0;
                y_d = (base_y == YW'(V_ACTIVE - 1)) ? '0 : base_y + YW'(1);
            end else begin
                x_d = base_x + XW'(1);
                y_d = base_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SYNC;
            out_pix_q     <= '0;
            out_valid_q   <= 1'b0;
            out_first_q   <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            in_rdy_q      <= 1'b0;
            frame_start   <= 1'b0;
            underflow_cnt <= '0;
            resync_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            out_pix_q   <= out_pix_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            x_q         <= x_d;
            y_q         <= y_d;
            in_rdy_q    <= in_rdy_d;
            frame_start <= consume && out_first_q;
            if (underflow_evt && (underflow_cnt != '1)) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
            if (resync_evt && (resync_cnt != '1)) begin
                resync_cnt <= resync_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_pixel_feeder.sv
// Directed bench for hdmi_pixel_feeder on a 4x2 raster with a 512-entry FIFO.
module tb_hdmi_pixel_feeder;

    localparam int H = 4;
    localparam int V = 2;
    localparam int D = 512;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [9:0]  fill;
    logic [15:0] underflow_cnt;
    logic [7:0]  resync_cnt;

    hdmi_pixel_feeder_if vid ();

    hdmi_pixel_feeder #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .DEPTH    (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vid           (vid),
        .frame_start   (frame_start),
        .fill          (fill),
        .underflow_cnt (underflow_cnt),
        .resync_cnt    (resync_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [24:0] src_q [$];
    logic [23:0] cap_q [$];
    logic [23:0] exp_q [$];
    int          acc_cnt;
    int          fs_cnt;

    function automatic logic [23:0] pix(input int k);
        logic [15:0] kk;
        kk = k[15:0];
        return {kk[7:0] ^ 8'hC3, kk[15:8], kk[7:0]};
    endfunction

    task automatic push_pix(input int k, input bit sof);
        src_q.push_back({sof, pix(k)});
        exp_q.push_back(pix(k));
    endtask

    task automatic push_junk(input int k);
        src_q.push_back({1'b0, pix(k)});
    endtask

    // one clock: present queue head, record handshakes that complete on this edge
    task automatic step();
        bit acc;
        bit cons;
        vid.in_valid = (src_q.size() != 0);
        if (src_q.size() != 0) begin
            {vid.in_sof, vid.in_data} = src_q[0];
        end else begin
            vid.in_sof  = 1'b0;
            vid.in_data = '0;
        end
        acc  = vid.in_valid && vid.in_rdy;
        cons = vid.video_valid && vid.video_rdy;
        if (cons) cap_q.push_back({vid.r, vid.g, vid.b});
        @(posedge clk);
        #1;
        if (acc) begin
            void'(src_q.pop_front());
            acc_cnt++;
        end
        if (frame_start) fs_cnt++;
        vid.in_valid = (src_q.size() != 0);
    endtask

    task automatic clear_bench();
        src_q.delete();
        cap_q.delete();
        exp_q.delete();
        acc_cnt = 0;
        fs_cnt  = 0;
    endtask

    task automatic apply_reset();
        clear_bench();
        vid.video_rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic check_stream(input string name);
        vectors++;
        if (cap_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s count: got %0d pixels, want %0d", name, cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            vectors++;
            if (cap_q[i] !== exp_q[i]) begin
                miscompares++;
                if (miscompares < 20)
                    $display("FAIL %s pixel %0d: got %h, want %h", name, i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        clear_bench();
        rst = 1'b1;
        vid.video_rdy = 1'b0;
        step();
        step();
        vectors++;
        if ({vid.r, vid.g, vid.b, vid.video_valid, vid.in_rdy, frame_start} !== 28'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rgb=%h vv=%b rdy=%b fs=%b, want all 0",
                     {vid.r, vid.g, vid.b}, vid.video_valid, vid.in_rdy, frame_start);
        end
        vectors++;
        if (fill !== 10'd0 || underflow_cnt !== 16'd0 || resync_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_counts: got fill=%0d uf=%0d rs=%0d, want 0 0 0",
                     fill, underflow_cnt, resync_cnt);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (vid.in_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_rdy: got %b, want 1", vid.in_rdy);
        end
    endtask

    task automatic test_basic_stream();
        apply_reset();
        for (int k = 0; k < 8; k++) push_pix(k, k == 0);
        vid.video_rdy = 1'b1;
        step();
        vectors++;
        if (vid.video_valid !== 1'b0 || fill !== 10'd1) begin
            miscompares++;
            $display("FAIL basic_first_edge: got vv=%b fill=%0d, want vv=0 fill=1", vid.video_valid, fill);
        end
        step();
        vectors++;
        if (vid.video_valid !== 1'b1 || {vid.r, vid.g, vid.b} !== pix(0)) begin
            miscompares++;
            $display("FAIL basic_latency: got vv=%b rgb=%h, want vv=1 rgb=%h",
                     vid.video_valid, {vid.r, vid.g, vid.b}, pix(0));
        end
        for (int i = 0; i < 60 && cap_q.size() < 8; i++) step();
        vid.video_rdy = 1'b0;
        check_stream("basic");
        vectors++;
        if (fs_cnt !== 1 || resync_cnt !== 8'd0 || underflow_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL basic_stats: got fs=%0d rs=%0d uf=%0d, want 1 0 0", fs_cnt, resync_cnt, underflow_cnt);
        end
    endtask

    task automatic test_leading_garbage();
        apply_reset();
        for (int k = 100; k < 103; k++) push_junk(k);
        for (int k = 0; k < 8; k++) push_pix(k, k == 0);
        vid.video_rdy = 1'b1;
        for (int i = 0; i < 60 && cap_q.size() < 8; i++) step();
        vid.video_rdy = 1'b0;
        check_stream("garbage");
        vectors++;
        if (resync_cnt !== 8'd0 || fs_cnt !== 1) begin
            miscompares++;
            $display("FAIL garbage_stats: got rs=%0d fs=%0d, want 0 1", resync_cnt, fs_cnt);
        end
    endtask

    task automatic test_early_sof();
        apply_reset();
        for (int k = 0; k < 6; k++) push_pix(k, k == 0);
        for (int k = 10; k < 18; k++) push_pix(k, k == 10);
        vid.video_rdy = 1'b1;
        for (int i = 0; i < 80 && cap_q.size() < 14; i++) step();
        vid.video_rdy = 1'b0;
        check_stream("early_sof");
        vectors++;
        if (resync_cnt !== 8'd1 || fs_cnt !== 2) begin
            miscompares++;
            $display("FAIL early_sof_stats: got rs=%0d fs=%0d, want 1 2", resync_cnt, fs_cnt);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        for (int k = 0; k < 3; k++) push_pix(k, k == 0);
        for (int i = 0; i < 20 && src_q.size() != 0; i++) step();
        step();
        step();
        vid.video_rdy = 1'b1;
        for (int i = 0; i < 20 && cap_q.size() < 3; i++) step();
        for (int i = 0; i < 10; i++) step();
        vid.video_rdy = 1'b0;
        vectors++;
        if (underflow_cnt !== 16'd10) begin
            miscompares++;
            $display("FAIL underflow_count: got %0d, want 10", underflow_cnt);
        end
        for (int k = 3; k < 8; k++) push_pix(k, 1'b0);
        for (int k = 20; k < 28; k++) push_pix(k, k == 20);
        step();
        step();
        vid.video_rdy = 1'b1;
        for (int i = 0; i < 80 && cap_q.size() < 16; i++) step();
        vid.video_rdy = 1'b0;
        check_stream("underflow_resume");
        vectors++;
        if (underflow_cnt !== 16'd10 || resync_cnt !== 8'd0 || fs_cnt !== 2) begin
            miscompares++;
            $display("FAIL underflow_stats: got uf=%0d rs=%0d fs=%0d, want 10 0 2",
                     underflow_cnt, resync_cnt, fs_cnt);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int k = 0; k < D + 5; k++) push_pix(k, (k % 8) == 0);
        for (int i = 0; i < 700 && vid.in_rdy; i++) step();
        vectors++;
        if (acc_cnt !== D + 1 || fill !== 10'(D) || vid.in_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full: got acc=%0d fill=%0d rdy=%b, want %0d %0d 0", acc_cnt, fill, vid.in_rdy, D + 1, D);
        end
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (acc_cnt !== D + 1 || vid.video_valid !== 1'b1 || {vid.r, vid.g, vid.b} !== pix(0)) begin
            miscompares++;
            $display("FAIL bp_hold: got acc=%0d vv=%b rgb=%h, want %0d 1 %h",
                     acc_cnt, vid.video_valid, {vid.r, vid.g, vid.b}, D + 1, pix(0));
        end
        vid.video_rdy = 1'b1;
        step();
        vectors++;
        if (vid.in_rdy !== 1'b1 || fill !== 10'(D - 1)) begin
            miscompares++;
            $display("FAIL bp_release: got rdy=%b fill=%0d, want 1 %0d", vid.in_rdy, fill, D - 1);
        end
        for (int i = 0; i < 1500 && cap_q.size() < D + 5; i++) step();
        vid.video_rdy = 1'b0;
        check_stream("backpressure");
        vectors++;
        if (fs_cnt !== 65 || resync_cnt !== 8'd0 || underflow_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL bp_stats: got fs=%0d rs=%0d uf=%0d, want 65 0 0", fs_cnt, resync_cnt, underflow_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        for (int k = 0; k < 22; k++) src_q.push_back({(k % 8) == 0, pix(k)});
        for (int i = 0; i < 40 && acc_cnt < 21; i++) step();
        vectors++;
        if (fill !== 10'd20) begin
            miscompares++;
            $display("FAIL midrst_fill_before: got %0d, want 20", fill);
        end
        clear_bench();
        rst = 1'b1;
        step();
        vectors++;
        if (fill !== 10'd0 || vid.video_valid !== 1'b0 || vid.in_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_cleared: got fill=%0d vv=%b rdy=%b, want 0 0 0", fill, vid.video_valid, vid.in_rdy);
        end
        rst = 1'b0;
        step();
        push_junk(200);
        for (int k = 40; k < 48; k++) push_pix(k, k == 40);
        vid.video_rdy = 1'b1;
        for (int i = 0; i < 60 && cap_q.size() < 8; i++) step();
        vid.video_rdy = 1'b0;
        check_stream("midrst");
        vectors++;
        if (resync_cnt !== 8'd0 || underflow_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL midrst_stats: got rs=%0d uf=%0d, want 0 0", resync_cnt, underflow_cnt);
        end
    endtask

    initial begin
        rst           = 1'b1;
        vid.in_data   = '0;
        vid.in_sof    = 1'b0;
        vid.in_valid  = 1'b0;
        vid.video_rdy = 1'b0;
        test_reset();
        test_basic_stream();
        test_leading_garbage();
        test_early_sof();
        test_underflow();
        test_backpressure();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
